// File: rtl/a2d_sched.sv
// a2d_sched: round-robin ADC128S conversion scheduler for the left/right load cells and battery.
// The force request port is named force_req because "force" is a reserved word in SystemVerilog.
module a2d_sched #(
    parameter int unsigned PERIOD_W = 18,
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_BATT  = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        force_req,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        rnd_vld,
    output logic        busy
);

    // state  | meaning
    // IDLE   | no round in progress, waiting for tick or force
    // WRT    | spi_wrt pulse cycle for transaction k
    // WAIT   | waiting for spi_done of transaction k
    // GAP    | one idle cycle so SS_n deasserts between transactions
    // DONE   | rnd_vld cycle; restart immediately if a trigger is pending
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRT,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [PERIOD_W-1:0] TIMER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [1:0]          k;
    logic                pend;
    logic [PERIOD_W-1:0] timer;
    logic                tick;
    logic                trigger;
    logic                unused_rd;

    assign unused_rd = ^spi_rd[15:12];
    assign tick      = en & (&timer);
    assign trigger   = tick | force_req;

    // Transaction 3 re-requests the left channel as a dummy to clock out the battery result.
    function automatic logic [15:0] cmd_word(input logic [1:0] idx);
        logic [2:0] ch;
        case (idx)
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_BATT;
            default: ch = CH_LFT;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            k       <= 2'd0;
            pend    <= 1'b0;
            spi_wrt <= 1'b0;
            spi_cmd <= 16'h0000;
            lft_ld  <= 12'h000;
            rght_ld <= 12'h000;
            batt    <= 12'h000;
            rnd_vld <= 1'b0;
            busy    <= 1'b0;
        end else begin
            spi_wrt <= 1'b0;
            rnd_vld <= 1'b0;
            if (trigger && (state != S_IDLE)) begin
                pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        k       <= 2'd0;
                        spi_cmd <= cmd_word(2'd0);
                        spi_wrt <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_WRT;
                    end
                end
                S_WRT: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_done) begin
                        // ADC returns the previous request, so result k belongs to channel k-1
                        case (k)
                            2'd1:    lft_ld  <= spi_rd[11:0];
                            2'd2:    rght_ld <= spi_rd[11:0];
                            2'd3:    batt    <= spi_rd[11:0];
                            default: ;
                        endcase
                        if (k == 2'd3) begin
                            rnd_vld <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            k     <= k + 2'd1;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    spi_cmd <= cmd_word(k);
                    spi_wrt <= 1'b1;
                    state   <= S_WRT;
                end
                S_DONE: begin
                    if (pend || trigger) begin
                        pend    <= 1'b0;
                        k       <= 2'd0;
                        spi_cmd <= cmd_word(2'd0);
                        spi_wrt <= 1'b1;
                        state   <= S_WRT;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
